ifetch_iq: RTL and testbench
============================

# ifetch_iq

Parametrised instruction-fetch unit with an internal instruction queue; successor to the single-register fetch stage. It sits between the instruction cache and the decoder. It issues sequential fetch requests and buffers up to IQ_DEPTH fetched instructions. It decouples the decoder through a valid/ready handshake. It redirects in-stage on JAL and on statically predicted-taken branches, stalls only on JALR, and recovers from decoder or ROB redirects.

## Interface
- ADDR_WIDTH, 32, PC/address width
- INST_WIDTH, 32, instruction width (opcode in [6:0])
- IQ_DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, fetch PC after reset
- BTFN_EN, 1, 1: backward B-type predicted taken; 0: all B-type predicted not taken
- clk  in  1  clock; all state updates on rising edge
- rst_in  in  1  reset, asynchronous, active-high
- rdy_in  in  1  global ready; low freezes all state
- cache_rdy  in  1  inst_in valid for address next_PC
- inst_in  in  INST_WIDTH  fetched instruction
- next_PC  out  ADDR_WIDTH  fetch address to cache
- next_inst  out  1  fetch request to cache
- if2dec  out  1  queue head valid
- dec_ready  in  1  decoder accepts head
- inst_out  out  INST_WIDTH  head instruction
- pc_out  out  ADDR_WIDTH  head PC
- pred_taken  out  1  head was redirected in fetch (JAL or predicted-taken B)
- decFlush  in  1  decoder redirect
- dec2if  in  ADDR_WIDTH  decoder redirect target
- robFlush  in  1  ROB redirect (mispredict/exception)
- rob2if  in  ADDR_WIDTH  ROB redirect target

## Operation
- State: fetch PC register, mode {RUN, STALL}, circular queue of {inst, pc, pred}, head/tail pointers (log2(IQ_DEPTH) bits), count (log2(IQ_DEPTH)+1 bits).
- next_inst = (mode==RUN) && (count < IQ_DEPTH). next_PC = fetch PC and must stay stable while next_inst is high.
- Push: when rdy_in && next_inst && cache_rdy and no flush. Write {inst_in, next_PC, pred} at tail. cache_rdy while next_inst is low is ignored.
- Fetch PC update on push, by inst_in[6:0]:
  - JAL (1101111): PC ← next_PC + immJ; pred=1.
  - B (1100011): if BTFN_EN && immB<0, PC ← next_PC + immB and pred=1. Otherwise PC ← next_PC+4 and pred=0.
  - JALR (1100111): PC ← next_PC+4; pred=0; mode ← STALL.
  - Other opcodes: PC ← next_PC+4; pred=0.
- Immediates:
  - immJ = sext{inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - immB = sext{inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - PC adds wrap modulo 2^ADDR_WIDTH.
- Pop: when rdy_in && if2dec && dec_ready and no flush; head advances.
  - if2dec = (count != 0).
  - inst_out, pc_out and pred_taken show the head entry, forced to 0 when the queue is empty.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo IQ_DEPTH.
- Flush priority: robFlush > decFlush. On either flush (with rdy_in high):
  - queue cleared (count=0, head=tail);
  - fetch PC ← rob2if or dec2if;
  - mode ← RUN;
  - any cache response and any pop in that cycle are discarded.
- STALL leaves only via a flush. The decoder must issue decFlush with the resolved JALR target.
- rdy_in low: no push, no pop, no flush; all registers hold.

## Timing
- Reset (async, immediate on assertion): fetch PC=RESET_PC, mode=RUN, count=0. Outputs: next_PC=RESET_PC, next_inst=1, if2dec=0, inst_out=0, pc_out=0, pred_taken=0.
- Push at edge N: if2dec high from cycle N+1 if the queue was empty. Queue-through latency is 1 cycle.
- Redirect from JAL or predicted-taken B: next_PC shows the target in the cycle after the push. There is no bubble beyond the cache latency.
- Flush at edge N: next_PC=target and next_inst=1 in cycle N+1; if2dec=0 in cycle N+1.
- Full (count==IQ_DEPTH): next_inst=0 combinationally. With a simultaneous pop, the request resumes the next cycle, not in the same cycle.
- Reset asserted mid-stream discards queue contents and STALL immediately.

## Test plan
- Sequential fill: reset; cache returns ADDI (0x00000013) every cycle with dec_ready=0 and IQ_DEPTH=4. Required: entries at PC 0,4,8,C; next_inst=0 after the 4th push; next_PC=0x10. Set dec_ready=1: pops in order 0,4,8,C while fetch resumes.
- JAL redirect: at PC 0x100, inst 0x0100006F (jal x0,+16). Required: queued with pred_taken=1; next cycle next_PC=0x110.
- BTFN: at PC 0x200, beq with immB=-8 (0xFE000CE3). Required: pred_taken=1, next_PC=0x1F8. With forward immB=+8 (0x00000463): pred_taken=0, next_PC=0x204. With BTFN_EN=0: both cases next_PC=0x204.
- JALR stall: at PC 0x300, inst 0x00008067. Required: next_inst=0 thereafter. decFlush with dec2if=0x400: queue empty and next_PC=0x400, next_inst=1 next cycle.
- Flush priority: robFlush (rob2if=0x800) and decFlush (dec2if=0x900) together with a full queue and cache_rdy=1. Required: next cycle next_PC=0x800, count=0, cache response dropped.
- Freeze/reset: hold rdy_in=0 with cache_rdy=1 and dec_ready=1. Required: no state change. Assert rst_in asynchronously mid-stream: if2dec=0 and next_PC=RESET_PC before the next edge.

Source files
------------

// File: rtl/ifetch_iq.sv
// Instruction fetch unit with a circular instruction queue toward the decoder.
// Redirects at fetch on JAL and backward branches; stalls on JALR until a flush.
module ifetch_iq #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned IQ_DEPTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter bit          BTFN_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  cache_rdy,
    input  logic [INST_WIDTH-1:0] inst_in,
    output logic [ADDR_WIDTH-1:0] next_PC,
    output logic                  next_inst,
    output logic                  if2dec,
    input  logic                  dec_ready,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  pred_taken,
    input  logic                  decFlush,
    input  logic [ADDR_WIDTH-1:0] dec2if,
    input  logic                  robFlush,
    input  logic [ADDR_WIDTH-1:0] rob2if
);

    localparam int unsigned PtrW = $clog2(IQ_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [6:0] OpJal  = 7'b1101111;
    localparam logic [6:0] OpB    = 7'b1100011;
    localparam logic [6:0] OpJalr = 7'b1100111;

    typedef enum logic {StRun, StStall} mode_e;

    mode_e                 mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]       count_q, count_d;

    logic [INST_WIDTH-1:0] inst_mem [IQ_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [IQ_DEPTH];
    logic                  pred_mem [IQ_DEPTH];

    logic                  flush, push, pop;
    logic                  push_pred;
    logic [ADDR_WIDTH-1:0] imm_j, imm_b, seq_pc;

    assign next_PC   = pc_q;
    assign next_inst = (mode_q == StRun) && (count_q < CntW'(IQ_DEPTH));
    assign if2dec    = (count_q != '0);

    assign inst_out   = if2dec ? inst_mem[head_q] : '0;
    assign pc_out     = if2dec ? pc_mem[head_q]   : '0;
    assign pred_taken = if2dec ? pred_mem[head_q] : 1'b0;

    assign flush = rdy_in && (robFlush || decFlush);
    assign push  = rdy_in && next_inst && cache_rdy && !flush;
    assign pop   = rdy_in && if2dec && dec_ready && !flush;

    assign imm_j  = {{(ADDR_WIDTH-21){inst_in[31]}}, inst_in[31], inst_in[19:12], inst_in[20],
                     inst_in[30:21], 1'b0};
    assign imm_b  = {{(ADDR_WIDTH-13){inst_in[31]}}, inst_in[31], inst_in[7], inst_in[30:25],
                     inst_in[11:8], 1'b0};
    assign seq_pc = pc_q + ADDR_WIDTH'(4);

    // Static prediction: JAL always, B-type only when the offset is backward.
    always_comb begin
        push_pred = 1'b0;
        if (inst_in[6:0] == OpJal) begin
            push_pred = 1'b1;
        end else if (inst_in[6:0] == OpB && BTFN_EN && inst_in[31]) begin
            push_pred = 1'b1;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        mode_d  = mode_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            pc_d    = robFlush ? rob2if : dec2if;
            mode_d  = StRun;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PtrW'(1);
                if (inst_in[6:0] == OpJal) begin
                    pc_d = pc_q + imm_j;
                end else if (push_pred) begin
                    pc_d = pc_q + imm_b;
                end else begin
                    pc_d = seq_pc;
                end
                if (inst_in[6:0] == OpJalr) begin
                    mode_d = StStall;
                end
            end
            if (pop) begin
                head_d = head_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            pc_q    <= RESET_PC;
            mode_q  <= StRun;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            mode_q  <= mode_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[tail_q] <= inst_in;
            pc_mem[tail_q]   <= pc_q;
            pred_mem[tail_q] <= push_pred;
        end
    end

endmodule

// File: tb/tb_ifetch_iq.sv
// Scoreboard bench for ifetch_iq: expected queue entries are produced from the
// driven cache responses and checked as the decoder side pops them.
module tb_ifetch_iq;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        cache_rdy = 1'b0;
    logic [31:0] inst_in = '0;
    logic        dec_ready = 1'b0;
    logic        decFlush = 1'b0;
    logic [31:0] dec2if = '0;
    logic        robFlush = 1'b0;
    logic [31:0] rob2if = '0;

    logic [31:0] next_PC, inst_out, pc_out;
    logic        next_inst, if2dec, pred_taken;
    logic [31:0] nb_next_PC, nb_inst_out, nb_pc_out;
    logic        nb_next_inst, nb_if2dec, nb_pred_taken;

    ifetch_iq #(.ADDR_WIDTH(32), .INST_WIDTH(32), .IQ_DEPTH(DEPTH), .RESET_PC(32'h0),
                .BTFN_EN(1'b1)) dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .cache_rdy(cache_rdy), .inst_in(inst_in),
        .next_PC(next_PC), .next_inst(next_inst), .if2dec(if2dec), .dec_ready(dec_ready),
        .inst_out(inst_out), .pc_out(pc_out), .pred_taken(pred_taken), .decFlush(decFlush),
        .dec2if(dec2if), .robFlush(robFlush), .rob2if(rob2if)
    );

    ifetch_iq #(.ADDR_WIDTH(32), .INST_WIDTH(32), .IQ_DEPTH(DEPTH), .RESET_PC(32'h0),
                .BTFN_EN(1'b0)) dut_nb (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .cache_rdy(cache_rdy), .inst_in(inst_in),
        .next_PC(nb_next_PC), .next_inst(nb_next_inst), .if2dec(nb_if2dec),
        .dec_ready(dec_ready), .inst_out(nb_inst_out), .pc_out(nb_pc_out),
        .pred_taken(nb_pred_taken), .decFlush(decFlush), .dec2if(dec2if),
        .robFlush(robFlush), .rob2if(rob2if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    ent_t        sb[$];
    logic [31:0] mpc = '0;
    logic        mrun = 1'b1;
    bit          mon_en = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic logic [31:0] model_target(input logic [31:0] pc, input logic [31:0] i,
                                                 output logic pred, output logic stall);
        logic [31:0] ij, ib;
        ij = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        ib = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        pred = 1'b0;
        stall = 1'b0;
        if (i[6:0] == 7'h6F) begin
            pred = 1'b1;
            return pc + ij;
        end
        if (i[6:0] == 7'h63 && i[31]) begin
            pred = 1'b1;
            return pc + ib;
        end
        if (i[6:0] == 7'h67) stall = 1'b1;
        return pc + 32'd4;
    endfunction

    // Drive one cycle of stimulus and record what the queue must hold after the edge.
    task automatic cyc(input logic cr, input logic [31:0] ins, input logic dr,
                       input logic rdy = 1'b1, input logic df = 1'b0, input logic [31:0] dt = '0,
                       input logic rf = 1'b0, input logic [31:0] rt = '0);
        logic        fl, ps, pr, st;
        logic [31:0] npc;
        ent_t        e;
        rdy_in = rdy; cache_rdy = cr; inst_in = ins; dec_ready = dr;
        decFlush = df; dec2if = dt; robFlush = rf; rob2if = rt;
        fl  = rdy && (rf || df);
        ps  = rdy && !fl && cr && mrun && (sb.size() < DEPTH);
        npc = model_target(mpc, ins, pr, st);
        e.inst = ins; e.pc = mpc; e.pred = pr;
        @(posedge clk);
        if (fl) begin
            sb.delete();
            mpc  = rf ? rt : dt;
            mrun = 1'b1;
        end else if (ps) begin
            sb.push_back(e);
            mpc = npc;
            if (st) mrun = 1'b0;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            n_chk++;
            if (next_inst !== (mrun && sb.size() < DEPTH)) begin
                n_fail++;
                $display("FAIL mon_next_inst got %b want %b", next_inst, mrun && sb.size() < DEPTH);
            end
            n_chk++;
            if (next_PC !== mpc) begin
                n_fail++;
                $display("FAIL mon_next_PC got %h want %h", next_PC, mpc);
            end
            n_chk++;
            if (if2dec !== (sb.size() != 0)) begin
                n_fail++;
                $display("FAIL mon_if2dec got %b want %b", if2dec, sb.size() != 0);
            end
            n_chk++;
            if (sb.size() == 0) begin
                if ({inst_out, pc_out, pred_taken} !== 65'h0) begin
                    n_fail++;
                    $display("FAIL mon_empty_head got %h/%h/%b want 0", inst_out, pc_out,
                             pred_taken);
                end
            end else begin
                if (inst_out !== sb[0].inst || pc_out !== sb[0].pc
                    || pred_taken !== sb[0].pred) begin
                    n_fail++;
                    $display("FAIL mon_head got %h/%h/%b want %h/%h/%b", inst_out, pc_out,
                             pred_taken, sb[0].inst, sb[0].pc, sb[0].pred);
                end
                if (rdy_in && dec_ready && !decFlush && !robFlush) void'(sb.pop_front());
            end
        end
    end

    task automatic test_reset();
        mon_en = 1'b0;
        rst_in = 1'b1;
        #2;
        n_chk++;
        if (next_PC !== 32'h0 || next_inst !== 1'b1 || if2dec !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got pc=%h req=%b v=%b want 0/1/0", next_PC, next_inst, if2dec);
        end
        n_chk++;
        if (inst_out !== 32'h0 || pc_out !== 32'h0 || pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_head got %h/%h/%b want 0", inst_out, pc_out, pred_taken);
        end
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        sb.delete(); mpc = 32'h0; mrun = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h13, 1'b0);
        n_chk++;
        if (next_inst !== 1'b0 || next_PC !== 32'h10) begin
            n_fail++;
            $display("FAIL fill_full got req=%b pc=%h want 0/00000010", next_inst, next_PC);
        end
        n_chk++;
        if (pc_out !== 32'h0) begin
            n_fail++;
            $display("FAIL fill_head got %h want 00000000", pc_out);
        end
        cyc(1'b1, 32'h13, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 32'h13, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 1'b1);
        n_chk++;
        if (if2dec !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_drain got %b want 0", if2dec);
        end
    endtask

    task automatic test_jal();
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h100);
        cyc(1'b1, 32'h0100006F, 1'b0);
        n_chk++;
        if (next_PC !== 32'h110 || pc_out !== 32'h100 || pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL jal got pc=%h head=%h pred=%b want 110/100/1", next_PC, pc_out,
                     pred_taken);
        end
        cyc(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_btfn();
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h200);
        cyc(1'b1, 32'hFE000CE3, 1'b0);
        n_chk++;
        if (next_PC !== 32'h1F8 || pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL btfn_back got pc=%h pred=%b want 1f8/1", next_PC, pred_taken);
        end
        n_chk++;
        if (nb_next_PC !== 32'h204 || nb_pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL btfn_off_back got pc=%h pred=%b want 204/0", nb_next_PC, nb_pred_taken);
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h200);
        cyc(1'b1, 32'h00000463, 1'b0);
        n_chk++;
        if (next_PC !== 32'h204 || pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL btfn_fwd got pc=%h pred=%b want 204/0", next_PC, pred_taken);
        end
        n_chk++;
        if (nb_next_PC !== 32'h204) begin
            n_fail++;
            $display("FAIL btfn_off_fwd got pc=%h want 204", nb_next_PC);
        end
        cyc(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_jalr();
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h300);
        cyc(1'b1, 32'h00008067, 1'b0);
        n_chk++;
        if (next_inst !== 1'b0) begin
            n_fail++;
            $display("FAIL jalr_stall got %b want 0", next_inst);
        end
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h13, 1'b1);
        n_chk++;
        if (next_inst !== 1'b0 || next_PC !== 32'h304 || if2dec !== 1'b0) begin
            n_fail++;
            $display("FAIL jalr_hold got req=%b pc=%h v=%b want 0/304/0", next_inst, next_PC,
                     if2dec);
        end
        cyc(1'b1, 32'h13, 1'b0, 1'b1, 1'b1, 32'h400);
        n_chk++;
        if (next_PC !== 32'h400 || next_inst !== 1'b1 || if2dec !== 1'b0) begin
            n_fail++;
            $display("FAIL jalr_flush got pc=%h req=%b v=%b want 400/1/0", next_PC, next_inst,
                     if2dec);
        end
    endtask

    task automatic test_flush_priority();
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h13, 1'b0);
        n_chk++;
        if (next_inst !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_full got %b want 0", next_inst);
        end
        cyc(1'b1, 32'h13, 1'b1, 1'b1, 1'b1, 32'h900, 1'b1, 32'h800);
        n_chk++;
        if (next_PC !== 32'h800 || if2dec !== 1'b0 || next_inst !== 1'b1) begin
            n_fail++;
            $display("FAIL prio got pc=%h v=%b req=%b want 800/0/1", next_PC, if2dec, next_inst);
        end
    endtask

    task automatic test_freeze();
        cyc(1'b1, 32'h13, 1'b0);
        cyc(1'b1, 32'h13, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h6F, 1'b1, 1'b0, i == 1, 32'hA00);
        n_chk++;
        if (next_PC !== 32'h808 || pc_out !== 32'h800 || if2dec !== 1'b1) begin
            n_fail++;
            $display("FAIL freeze got pc=%h head=%h v=%b want 808/800/1", next_PC, pc_out, if2dec);
        end
    endtask

    task automatic test_async_reset();
        cyc(1'b1, 32'h13, 1'b1);
        cyc(1'b1, 32'h00008067, 1'b0);
        #2;
        mon_en = 1'b0;
        rst_in = 1'b1;
        #1;
        n_chk++;
        if (if2dec !== 1'b0 || next_PC !== 32'h0 || next_inst !== 1'b1) begin
            n_fail++;
            $display("FAIL async_rst got v=%b pc=%h req=%b want 0/0/1", if2dec, next_PC, next_inst);
        end
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        sb.delete(); mpc = 32'h0; mrun = 1'b1;
        mon_en = 1'b1;
        cyc(1'b1, 32'h13, 1'b0);
        n_chk++;
        if (pc_out !== 32'h0 || next_PC !== 32'h4) begin
            n_fail++;
            $display("FAIL post_rst got head=%h pc=%h want 0/4", pc_out, next_PC);
        end
        cyc(1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_jal();
        test_btfn();
        test_jalr();
        test_flush_priority();
        test_freeze();
        test_async_reset();
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
